// File: rtl/rap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rap_pkg
// Description : Shared opcodes, status-word layout, FSM state encodings and
//               the queued-move record for the SPI move sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rap_pkg;

    // Command opcodes carried in word[31:24] of the first word of a command
    localparam logic [7:0] c_op_move   = 8'h01;
    localparam logic [7:0] c_op_enable = 8'h02;
    localparam logic [7:0] c_op_stop   = 8'h03;
    localparam logic [7:0] c_op_clear  = 8'h04;

    // Status reply layout
    localparam logic [7:0] c_status_tag   = 8'hA5;
    localparam int         c_st_busy      = 0;
    localparam int         c_st_enable    = 1;
    localparam int         c_st_fault     = 2;
    localparam int         c_st_overflow  = 3;
    localparam int         c_st_level_lsb = 4;
    localparam int         c_st_level_msb = 6;
    localparam int         c_st_tag_lsb   = 24;
    localparam int         c_st_tag_msb   = 31;

    // Command parser: one state per word of a MOVE command
    typedef enum logic [1:0] {
        P_OP  = 2'd0,
        P_CNT = 2'd1,
        P_PER = 2'd2
    } parser_state_t;

    // Step generator
    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_LOAD = 2'd1,
        G_HIGH = 2'd2,
        G_LOW  = 2'd3
    } gen_state_t;

    // One queued move: direction, step count, step period in clock cycles
    typedef struct packed {
        logic        dir;
        logic [31:0] count;
        logic [31:0] period;
    } move_t;

    localparam int c_move_w = $bits(move_t);

    // Periods shorter than the generator can produce are raised to the minimum
    function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                                 input logic [31:0] min_period);
        return (period < min_period) ? min_period : period;
    endfunction

endpackage
`default_nettype wire

// File: rtl/move_fifo.sv
`default_nettype none
// ============================================================================
// Module      : move_fifo
// Description : Synchronous FIFO for queued moves. A push into a full FIFO is
//               accepted when a pop happens in the same cycle. Flush empties
//               the FIFO in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module move_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4     // power of two, at least 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic [WIDTH-1:0]        i_data,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int            c_aw         = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full_level = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == c_full_level);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : move_sequencer
// Description : Decodes SPI command words, queues MOVE commands and plays
//               them out as step/dir pulse trains. Returns a registered
//               status word for the next SPI transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module move_sequencer
    import rap_pkg::*;
#(
    parameter int QDEPTH     = 4,   // power of two, at least 2
    parameter int MIN_PERIOD = 2    // at least 2 so both pulse halves are non-empty
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        word_received,
    input  logic [31:0] word_data,
    output logic [31:0] word_send_data,
    output logic        step,
    output logic        dir,
    output logic        enable,
    output logic        busy
);

    localparam int          c_lvl_w      = $clog2(QDEPTH) + 1;
    localparam logic [31:0] c_min_period = 32'(MIN_PERIOD);

    // Parser
    parser_state_t        r_pstate;
    parser_state_t        w_pstate_next;
    logic                 w_push;
    logic                 w_stop;
    logic                 w_set_fault;
    logic                 w_clear_flags;
    logic                 w_enable_we;
    logic                 w_latch_dir;
    logic                 w_latch_count;
    logic [7:0]           w_opcode;
    logic                 r_cmd_dir;
    logic [31:0]          r_cmd_count;
    logic                 r_enable;
    logic                 r_fault;
    logic                 r_overflow;
    logic                 w_drop;

    // Queue
    move_t                w_push_move;
    move_t                w_head;
    logic [c_move_w-1:0]  w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_lvl_w-1:0]   w_fifo_level;

    // Generator
    gen_state_t           r_gstate;
    gen_state_t           w_gstate_next;
    logic                 w_pop;
    logic [31:0]          r_timer;
    logic [31:0]          w_timer_next;
    logic [31:0]          r_count;
    logic [31:0]          w_count_next;
    logic [31:0]          r_period;
    logic [31:0]          w_period_next;
    logic [31:0]          w_half;
    logic                 r_dir;
    logic                 w_dir_next;
    logic                 r_step;
    logic                 w_busy;

    // Status
    logic [31:0]          w_status;
    logic [31:0]          r_status;

    assign w_opcode    = word_data[31:24];
    assign w_push_move = {r_cmd_dir, r_cmd_count, clamp_period(word_data, c_min_period)};
    assign w_head      = w_fifo_rdata;
    assign w_half      = r_period >> 1;
    assign w_drop      = w_push && w_fifo_full && !w_pop;
    assign w_busy      = (r_gstate != G_IDLE) || !w_fifo_empty;

    // Parser next state and command decode; only P_OP words are opcodes
    always_comb begin
        w_pstate_next = r_pstate;
        w_push        = 1'b0;
        w_stop        = 1'b0;
        w_set_fault   = 1'b0;
        w_clear_flags = 1'b0;
        w_enable_we   = 1'b0;
        w_latch_dir   = 1'b0;
        w_latch_count = 1'b0;
        if (word_received) begin
            case (r_pstate)
                P_OP: begin
                    case (w_opcode)
                        c_op_move: begin
                            w_latch_dir   = 1'b1;
                            w_pstate_next = P_CNT;
                        end
                        c_op_enable: w_enable_we   = 1'b1;
                        c_op_stop:   w_stop        = 1'b1;
                        c_op_clear:  w_clear_flags = 1'b1;
                        default:     w_set_fault   = 1'b1;
                    endcase
                end
                P_CNT: begin
                    w_latch_count = 1'b1;
                    w_pstate_next = P_PER;
                end
                P_PER: begin
                    w_push        = 1'b1;
                    w_pstate_next = P_OP;
                end
                default: w_pstate_next = P_OP;
            endcase
        end
    end

    // Parser state register
    always_ff @(posedge CLK) begin
        if (reset) r_pstate <= P_OP;
        else       r_pstate <= w_pstate_next;
    end

    // Partial-command fields, enable and sticky flags
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cmd_dir   <= 1'b0;
            r_cmd_count <= '0;
            r_enable    <= 1'b0;
            r_fault     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_latch_dir)   r_cmd_dir   <= word_data[0];
            if (w_latch_count) r_cmd_count <= word_data;
            if (w_enable_we)   r_enable    <= word_data[0];
            if (w_clear_flags) begin
                r_fault    <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (w_set_fault) r_fault    <= 1'b1;
                if (w_drop)      r_overflow <= 1'b1;
            end
        end
    end

    move_fifo #(
        .WIDTH (c_move_w),
        .DEPTH (QDEPTH)
    ) u_move_fifo (
        .clk     (CLK),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_stop),
        .i_data  (w_push_move),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    // Generator next state; a pop latches the move so dir is settled in G_LOAD
    always_comb begin
        w_gstate_next = r_gstate;
        w_pop         = 1'b0;
        w_timer_next  = r_timer;
        w_count_next  = r_count;
        w_period_next = r_period;
        w_dir_next    = r_dir;
        if (w_stop) begin
            w_gstate_next = G_IDLE;
        end else begin
            case (r_gstate)
                G_IDLE: begin
                    if (!w_fifo_empty) begin
                        w_pop         = 1'b1;
                        w_gstate_next = G_LOAD;
                        w_dir_next    = w_head.dir;
                        w_count_next  = w_head.count;
                        w_period_next = w_head.period;
                    end
                end
                G_LOAD: begin
                    if (r_count == 32'd0) begin
                        w_gstate_next = G_IDLE;
                    end else begin
                        w_gstate_next = G_HIGH;
                        w_timer_next  = w_half - 32'd1;
                    end
                end
                G_HIGH: begin
                    if (r_timer == 32'd0) begin
                        w_gstate_next = G_LOW;
                        w_timer_next  = r_period - w_half - 32'd1;
                    end else begin
                        w_timer_next  = r_timer - 32'd1;
                    end
                end
                G_LOW: begin
                    if (r_timer != 32'd0) begin
                        w_timer_next = r_timer - 32'd1;
                    end else begin
                        w_count_next = r_count - 32'd1;
                        if (r_count > 32'd1) begin
                            w_gstate_next = G_HIGH;
                            w_timer_next  = w_half - 32'd1;
                        end else if (!w_fifo_empty) begin
                            w_pop         = 1'b1;
                            w_gstate_next = G_LOAD;
                            w_dir_next    = w_head.dir;
                            w_count_next  = w_head.count;
                            w_period_next = w_head.period;
                        end else begin
                            w_gstate_next = G_IDLE;
                        end
                    end
                end
                default: w_gstate_next = G_IDLE;
            endcase
        end
    end

    // Generator registers; step is registered so it is glitch-free
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_gstate <= G_IDLE;
            r_timer  <= '0;
            r_count  <= '0;
            r_period <= '0;
            r_dir    <= 1'b0;
            r_step   <= 1'b0;
        end else begin
            r_gstate <= w_gstate_next;
            r_timer  <= w_timer_next;
            r_count  <= w_count_next;
            r_period <= w_period_next;
            r_dir    <= w_dir_next;
            r_step   <= (w_gstate_next == G_HIGH);
        end
    end

    // Status word assembly
    always_comb begin
        w_status                                = '0;
        w_status[c_st_tag_msb:c_st_tag_lsb]     = c_status_tag;
        w_status[c_st_level_msb:c_st_level_lsb] = 3'(w_fifo_level);
        w_status[c_st_overflow]                 = r_overflow;
        w_status[c_st_fault]                    = r_fault;
        w_status[c_st_enable]                   = r_enable;
        w_status[c_st_busy]                     = w_busy;
    end

    // Status reply register, one cycle behind the live state
    always_ff @(posedge CLK) begin
        if (reset) r_status <= {c_status_tag, 24'h0};
        else       r_status <= w_status;
    end

    assign word_send_data = r_status;
    assign step           = r_step;
    assign dir            = r_dir;
    assign enable         = r_enable;
    assign busy           = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_sequencer
// Description : Self-checking bench for move_sequencer. A timeline model
//               (queue of moves, elapsed-cycle arithmetic) predicts every
//               output cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_sequencer;

    localparam int QDEPTH     = 4;
    localparam int MIN_PERIOD = 2;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        word_received = 1'b0;
    logic [31:0] word_data = '0;
    logic [31:0] word_send_data;
    logic        step;
    logic        dir;
    logic        enable;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    move_sequencer #(
        .QDEPTH     (QDEPTH),
        .MIN_PERIOD (MIN_PERIOD)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .word_received  (word_received),
        .word_data      (word_data),
        .word_send_data (word_send_data),
        .step           (step),
        .dir            (dir),
        .enable         (enable),
        .busy           (busy)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit              dir;
        longint unsigned count;
        longint unsigned period;
    } mv_t;

    mv_t             mq[$];
    int              m_pst = 0;         // words of the current command seen so far
    bit              m_cdir = 0;
    longint unsigned m_ccnt = 0;
    bit              m_active = 0;      // a move is loaded; m_t counts cycles since its load cycle
    longint unsigned m_t = 0;
    mv_t             m_cur;
    bit              m_dir = 0, m_en = 0, m_fault = 0, m_ovf = 0;
    logic [31:0]     m_status = 32'hA500_0000;

    // Cycle t>=1 of a move lies in step (t-1)/P; step is high in its first P/2 cycles
    function automatic bit exp_step();
        if (!m_active || m_t == 0) return 1'b0;
        return ((m_t - 1) % m_cur.period) < (m_cur.period / 2);
    endfunction

    function automatic bit exp_busy();
        return m_active || (mq.size() != 0);
    endfunction

    task automatic model_update();
        bit              do_pop;
        bit              full_before;
        bit              stop_now;
        logic [7:0]      op;
        longint unsigned per;
        mv_t             nm;
        if (reset) begin
            mq.delete();
            m_pst = 0; m_active = 0; m_t = 0;
            m_dir = 0; m_en = 0; m_fault = 0; m_ovf = 0;
            m_status = 32'hA500_0000;
            return;
        end
        m_status = {8'hA5, 16'h0, 1'b0, 3'(mq.size()), m_ovf, m_fault, m_en, exp_busy()};
        op          = word_data[31:24];
        stop_now    = word_received && (m_pst == 0) && (op == 8'h03);
        full_before = (mq.size() == QDEPTH);
        do_pop      = 0;
        if (stop_now) begin
            mq.delete();
            m_active = 0;
        end else if (!m_active) begin
            do_pop = (mq.size() != 0);
        end else if (m_t == m_cur.count * m_cur.period) begin
            // A zero-step move always passes through idle; otherwise chain directly
            if (m_cur.count == 0) m_active = 0;
            else begin
                do_pop = (mq.size() != 0);
                if (!do_pop) m_active = 0;
            end
        end else begin
            m_t++;
        end
        if (do_pop) begin
            m_cur    = mq.pop_front();
            m_active = 1;
            m_t      = 0;
            m_dir    = m_cur.dir;
        end
        if (word_received) begin
            case (m_pst)
                0: begin
                    case (op)
                        8'h01: begin m_cdir = word_data[0]; m_pst = 1; end
                        8'h02: m_en = word_data[0];
                        8'h03: ;
                        8'h04: begin m_fault = 0; m_ovf = 0; end
                        default: m_fault = 1;
                    endcase
                end
                1: begin m_ccnt = word_data; m_pst = 2; end
                default: begin
                    per = (word_data < MIN_PERIOD) ? MIN_PERIOD : word_data;
                    nm.dir = m_cdir; nm.count = m_ccnt; nm.period = per;
                    if (!full_before || do_pop) mq.push_back(nm);
                    else m_ovf = 1;
                    m_pst = 0;
                end
            endcase
        end
    endtask

    // Drive one cycle of input, advance DUT and model, return at the falling edge
    task automatic tick(input logic rcv, input logic [31:0] d);
        word_received = rcv;
        word_data     = d;
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        word_received = 1'b0;
    endtask

    task automatic send_move(input logic d, input logic [31:0] cnt, input logic [31:0] per);
        tick(1'b1, {8'h01, 23'h0, d});
        tick(1'b1, cnt);
        tick(1'b1, per);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick(1'b1, 32'h0200_0001);   // strobe coincident with reset
        tick(1'b0, 32'h0);
        reset = 1'b0;
        checks++;
        if (word_send_data !== 32'hA500_0000) begin
            errors++; $display("FAIL reset_status got %h expected a5000000", word_send_data);
        end
        checks++;
        if ({step, dir, enable, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got step/dir/en/busy=%b expected 0000", {step, dir, enable, busy});
        end
        tick(1'b0, 32'h0);
        checks++;
        if (enable !== 1'b0 || word_send_data !== 32'hA500_0000) begin
            errors++; $display("FAIL reset_strobe_ignored got en=%b status=%h expected 0 a5000000", enable, word_send_data);
        end
    endtask

    task automatic test_basic_move();
        int pulses = 0;
        bit prev = 0;
        send_move(1'b1, 32'd3, 32'd4);   // now in cycle N+1
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({step, dir, busy, enable} !== {exp_step(), m_dir, exp_busy(), m_en}) begin
                errors++;
                $display("FAIL basic_cycle%0d got step/dir/busy/en=%b expected %b", i,
                         {step, dir, busy, enable}, {exp_step(), m_dir, exp_busy(), m_en});
            end
            if (i == 1) begin
                checks++;
                if (dir !== 1'b1 || step !== 1'b0) begin
                    errors++; $display("FAIL basic_load got dir=%b step=%b expected 1 0", dir, step);
                end
            end
            if (i == 2) begin
                checks++;
                if (step !== 1'b1) begin
                    errors++; $display("FAIL basic_first_rise got step=%b expected 1", step);
                end
            end
            if (step === 1'b1 && !prev) pulses++;
            prev = (step === 1'b1);
            tick(1'b0, 32'h0);
        end
        checks++;
        if (pulses != 3 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_pulses got pulses=%0d busy=%b expected 3 0", pulses, busy);
        end
    endtask

    task automatic test_enable_fault();
        tick(1'b1, 32'h7F00_0000);
        tick(1'b0, 32'h0);
        checks++;
        if (word_send_data !== m_status || word_send_data[2] !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL unknown_op got status=%h busy=%b expected %h 0", word_send_data, busy, m_status);
        end
        tick(1'b1, 32'h0200_0001);
        checks++;
        if (enable !== 1'b1) begin
            errors++; $display("FAIL enable_set got %b expected 1", enable);
        end
        tick(1'b1, 32'h0400_0000);
        tick(1'b0, 32'h0);
        checks++;
        if (word_send_data !== m_status || word_send_data[2:1] !== 2'b01) begin
            errors++; $display("FAIL clear_fault got status=%h expected %h", word_send_data, m_status);
        end
    endtask

    task automatic test_zero_and_min();
        int pulses = 0;
        int high_cycles = 0;
        bit prev = 0;
        send_move(1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({step, dir, busy} !== {exp_step(), m_dir, exp_busy()}) begin
                errors++;
                $display("FAIL zero_cycle%0d got step/dir/busy=%b expected %b", i,
                         {step, dir, busy}, {exp_step(), m_dir, exp_busy()});
            end
            if (step === 1'b1) pulses++;
            tick(1'b0, 32'h0);
        end
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_count got high_cycles=%0d busy=%b expected 0 0", pulses, busy);
        end
        pulses = 0;
        send_move(1'b1, 32'd2, 32'd1);   // period raised to the minimum of 2
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({step, dir, busy} !== {exp_step(), m_dir, exp_busy()}) begin
                errors++;
                $display("FAIL minper_cycle%0d got step/dir/busy=%b expected %b", i,
                         {step, dir, busy}, {exp_step(), m_dir, exp_busy()});
            end
            if (step === 1'b1) high_cycles++;
            if (step === 1'b1 && !prev) pulses++;
            prev = (step === 1'b1);
            tick(1'b0, 32'h0);
        end
        checks++;
        if (pulses != 2 || high_cycles != 2) begin
            errors++; $display("FAIL minper_shape got pulses=%0d high=%0d expected 2 2", pulses, high_cycles);
        end
    endtask

    task automatic test_overflow();
        // One move starts running at once, four wait in the queue, the sixth is dropped
        for (int k = 0; k < 6; k++) send_move(1'b1, 32'd100, 32'd10);
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);
        checks++;
        if (word_send_data !== m_status || word_send_data[6:3] !== 4'b1001) begin
            errors++; $display("FAIL overflow_status got %h expected %h with level 4 and overflow", word_send_data, m_status);
        end
        tick(1'b1, 32'h0400_0000);
        tick(1'b0, 32'h0);
        checks++;
        if (word_send_data !== m_status || word_send_data[3] !== 1'b0 || word_send_data[6:4] !== 3'd4) begin
            errors++; $display("FAIL overflow_clear got %h expected %h", word_send_data, m_status);
        end
        tick(1'b1, 32'h0300_0000);
        checks++;
        if (step !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL overflow_stop got step=%b busy=%b expected 0 0", step, busy);
        end
    endtask

    task automatic test_stop();
        send_move(1'b0, 32'd1000, 32'd8);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({step, dir, busy} !== {exp_step(), m_dir, exp_busy()}) begin
                errors++;
                $display("FAIL stop_run_cycle%0d got step/dir/busy=%b expected %b", i,
                         {step, dir, busy}, {exp_step(), m_dir, exp_busy()});
            end
            tick(1'b0, 32'h0);
        end
        tick(1'b1, 32'h0300_0000);
        checks++;
        if (step !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stop_abort got step=%b busy=%b expected 0 0", step, busy);
        end
        tick(1'b0, 32'h0);
        checks++;
        if (word_send_data !== m_status || word_send_data[6:4] !== 3'd0) begin
            errors++; $display("FAIL stop_level got %h expected %h", word_send_data, m_status);
        end
    endtask

    task automatic test_reset_midcmd();
        int pulses = 0;
        bit prev = 0;
        tick(1'b1, 32'h0100_0000);
        tick(1'b1, 32'd7);
        reset = 1'b1;
        tick(1'b0, 32'h0);
        reset = 1'b0;
        send_move(1'b1, 32'd2, 32'd4);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({step, dir, busy, enable} !== {exp_step(), m_dir, exp_busy(), m_en}) begin
                errors++;
                $display("FAIL midreset_cycle%0d got step/dir/busy/en=%b expected %b", i,
                         {step, dir, busy, enable}, {exp_step(), m_dir, exp_busy(), m_en});
            end
            if (step === 1'b1 && !prev) pulses++;
            prev = (step === 1'b1);
            tick(1'b0, 32'h0);
        end
        checks++;
        if (pulses != 2 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_pulses got %0d busy=%b expected 2 0", pulses, busy);
        end
    endtask

    task automatic test_random();
        logic        rcv;
        logic [31:0] d;
        int          sel;
        for (int i = 0; i < 400; i++) begin
            checks++;
            if ({step, dir, busy, enable} !== {exp_step(), m_dir, exp_busy(), m_en} ||
                word_send_data !== m_status) begin
                errors++;
                $display("FAIL random_cycle%0d got step/dir/busy/en=%b status=%h expected %b %h", i,
                         {step, dir, busy, enable}, word_send_data,
                         {exp_step(), m_dir, exp_busy(), m_en}, m_status);
            end
            rcv = ($urandom_range(0, 3) == 0);
            d   = '0;
            if (m_pst == 0) begin
                sel = $urandom_range(0, 19);
                if (sel < 10)       d = {8'h01, 23'h0, 1'($urandom)};
                else if (sel < 13)  d = {8'h02, 23'h0, 1'($urandom)};
                else if (sel < 14)  d = 32'h0300_0000;
                else if (sel < 17)  d = 32'h0400_0000;
                else                d = {8'($urandom_range(5, 255)), 24'($urandom)};
            end else if (m_pst == 1) begin
                d = 32'($urandom_range(0, 4));
            end else begin
                d = 32'($urandom_range(0, 6));
            end
            tick(rcv, d);
        end
    endtask

    initial begin
        test_reset();
        test_basic_move();
        test_enable_fault();
        test_zero_and_min();
        test_overflow();
        test_stop();
        test_reset_midcmd();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
